xalu_md: RTL and testbench

//  Multi-cycle multiply/divide unit (XALU) in the E stage of the 5-stage MIPS pipeline.

---
 rtl/xalu_md.sv | 168 ++++++++++++++++
 tb/tb_xalu_md.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/xalu_md.sv
// Multi-cycle multiply/divide unit holding HI/LO for the E stage.
// Optional macro XALU_MADD_EN adds madd/maddu/msub/msubu accumulate ops.
module xalu_md #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  XALUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] Out
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;
    localparam logic [3:0] OpMfhi  = 4'd7;
    localparam logic [3:0] OpMflo  = 4'd8;
`ifdef XALU_MADD_EN
    localparam logic [3:0] OpMadd  = 4'd9;
    localparam logic [3:0] OpMaddu = 4'd10;
    localparam logic [3:0] OpMsub  = 4'd11;
    localparam logic [3:0] OpMsubu = 4'd12;
`endif

    localparam logic StIdle = 1'b0;
    localparam logic StRun  = 1'b1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic [31:0]     phi_q, phi_d, plo_q, plo_d;
    logic            pvld_q, pvld_d;

    logic               state;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        divisor;
    logic               div_ovf;
    logic [31:0]        quot_s, rem_s, quot_u, rem_u;
`ifdef XALU_MADD_EN
    logic [63:0]        acc;
`endif

    assign state = (cnt_q != '0) ? StRun : StIdle;

    always_comb begin
        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'd0, A} * {32'd0, B};
        // Dividing by 1 covers both B==0 (result discarded) and INT_MIN/-1 (quot=A, rem=0).
        div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
        divisor = ((B == 32'd0) || div_ovf) ? 32'd1 : B;
        quot_s  = $signed(A) / $signed(divisor);
        rem_s   = $signed(A) % $signed(divisor);
        quot_u  = A / divisor;
        rem_u   = A % divisor;
`ifdef XALU_MADD_EN
        acc     = {hi_q, lo_q};
`endif
    end

    always_comb begin
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        phi_d  = phi_q;
        plo_d  = plo_q;
        pvld_d = pvld_q;
        case (state)
            StIdle: begin
                if (Start) begin
                    unique case (XALUOp)
                        OpMult: begin
                            cnt_d = CntW'(MULT_CYCLES);
                            {phi_d, plo_d} = prod_s;
                            pvld_d = 1'b1;
                        end
                        OpMultu: begin
                            cnt_d = CntW'(MULT_CYCLES);
                            {phi_d, plo_d} = prod_u;
                            pvld_d = 1'b1;
                        end
                        OpDiv: begin
                            cnt_d  = CntW'(DIV_CYCLES);
                            phi_d  = rem_s;
                            plo_d  = quot_s;
                            pvld_d = (B != 32'd0);
                        end
                        OpDivu: begin
                            cnt_d  = CntW'(DIV_CYCLES);
                            phi_d  = rem_u;
                            plo_d  = quot_u;
                            pvld_d = (B != 32'd0);
                        end
`ifdef XALU_MADD_EN
                        OpMadd: begin
                            cnt_d = CntW'(MULT_CYCLES);
                            {phi_d, plo_d} = acc + 64'(prod_s);
                            pvld_d = 1'b1;
                        end
                        OpMaddu: begin
                            cnt_d = CntW'(MULT_CYCLES);
                            {phi_d, plo_d} = acc + prod_u;
                            pvld_d = 1'b1;
                        end
                        OpMsub: begin
                            cnt_d = CntW'(MULT_CYCLES);
                            {phi_d, plo_d} = acc - 64'(prod_s);
                            pvld_d = 1'b1;
                        end
                        OpMsubu: begin
                            cnt_d = CntW'(MULT_CYCLES);
                            {phi_d, plo_d} = acc - prod_u;
                            pvld_d = 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end else if (XALUOp == OpMthi) begin
                    hi_d = A;
                end else if (XALUOp == OpMtlo) begin
                    lo_d = A;
                end
            end
            default: begin
                cnt_d = cnt_q - 1'b1;
                if ((cnt_q == CntW'(1)) && pvld_q) begin
                    hi_d = phi_q;
                    lo_d = plo_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            phi_q  <= '0;
            plo_q  <= '0;
            pvld_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            phi_q  <= phi_d;
            plo_q  <= plo_d;
            pvld_q <= pvld_d;
        end
    end

    assign Busy = Start | (cnt_q != '0);
    assign HI   = hi_q;
    assign LO   = lo_q;
    assign Out  = (XALUOp == OpMfhi) ? hi_q : (XALUOp == OpMflo) ? lo_q : 32'd0;

endmodule

// File: tb/tb_xalu_md.sv
// Directed bench for xalu_md: scoreboard of expected {HI,LO} per launched op,
// plus Busy length, mthi/mtlo, mfhi/mflo and reset-abort checks.
module tb_xalu_md;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [3:0]  XALUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] Out;

    int checks   = 0;
    int failures = 0;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    xalu_md #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .XALUOp(XALUOp),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO),
        .Out   (Out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change at negedge; outputs sampled 2ns later, before the next posedge.
    task automatic mt(input logic [3:0] op, input logic [31:0] val);
        @(negedge clk);
        Start = 1'b0; XALUOp = op; A = val; B = 32'd0;
        @(negedge clk);
        XALUOp = 4'd0; A = 32'd0;
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_busy,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int busy_cnt;
        logic [63:0] exp;
        sb_q.push_back({exp_hi, exp_lo});
        @(negedge clk);
        Start = 1'b1; XALUOp = op; A = a; B = b;
        #2;
        busy_cnt = Busy ? 1 : 0;
        @(negedge clk);
        Start = 1'b0; XALUOp = 4'd0; A = 32'd0; B = 32'd0;
        for (int i = 0; i < 64; i++) begin
            #2;
            if (!Busy) break;
            busy_cnt++;
            @(negedge clk);
        end
        check({tag, "_busy"}, 32'(busy_cnt), 32'(exp_busy));
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp = sb_q.pop_front();
            check({tag, "_hi"}, HI, exp[63:32]);
            check({tag, "_lo"}, LO, exp[31:0]);
        end
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; XALUOp = 4'd0; A = 32'd0; B = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #2;
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_out", Out, 32'd0);
        XALUOp = 4'd7;
        #1;
        check("rst_mfhi", Out, 32'd0);
        XALUOp = 4'd0;

        run_op("mult", 4'd1, 32'hFFFF_FFFD, 32'd7, 6, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        XALUOp = 4'd8;
        #1;
        check("mflo", Out, 32'hFFFF_FFEB);
        XALUOp = 4'd7;
        #1;
        check("mfhi", Out, 32'hFFFF_FFFF);
        XALUOp = 4'd0;

        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 6, 32'd1, 32'hFFFF_FFFE);
        run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 11, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_negb", 4'd3, 32'd7, 32'hFFFF_FFFE, 11, 32'd1, 32'hFFFF_FFFD);
        run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 11, 32'd0, 32'h8000_0000);
        run_op("divu", 4'd4, 32'd100, 32'd7, 11, 32'd2, 32'd14);

        mt(4'd5, 32'h11);
        mt(4'd6, 32'h22);
        #2;
        check("mthi", HI, 32'h11);
        check("mtlo", LO, 32'h22);
        run_op("divu_by0", 4'd4, 32'd5, 32'd0, 11, 32'h11, 32'h22);

        // Start op with invalid opcode launches nothing.
        @(negedge clk);
        Start = 1'b1; XALUOp = 4'd0; A = 32'd3; B = 32'd3;
        @(negedge clk);
        Start = 1'b0;
        #2;
        check("bad_op_busy", {31'd0, Busy}, 32'd0);

        // Mult, then ignored mthi and second Start, then reset aborts it.
        @(negedge clk);
        Start = 1'b1; XALUOp = 4'd1; A = 32'd4; B = 32'd4;
        @(negedge clk);
        Start = 1'b0; XALUOp = 4'd5; A = 32'h99;
        #2;
        check("run_busy", {31'd0, Busy}, 32'd1);
        @(negedge clk);
        Start = 1'b1; XALUOp = 4'd1; A = 32'd9; B = 32'd9;
        #2;
        check("mthi_ignored", HI, 32'h11);
        @(negedge clk);
        Start = 1'b0; XALUOp = 4'd0; A = 32'd0; B = 32'd0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #2;
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        repeat (12) @(negedge clk);
        #2;
        check("abort_nocommit_hi", HI, 32'd0);
        check("abort_nocommit_lo", LO, 32'd0);

`ifdef XALU_MADD_EN
        mt(4'd6, 32'd10);
        run_op("madd", 4'd9, 32'd2, 32'd3, 6, 32'd0, 32'd16);
        run_op("msubu", 4'd12, 32'd20, 32'd1, 6, 32'hFFFF_FFFF, 32'hFFFF_FFFC);
`else
        run_op("madd_off", 4'd9, 32'd2, 32'd3, 1, 32'd0, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
